i3c_target_sdr_responder: RTL and testbench

Target-side SDR private-transfer engine for an I3C device on the shared SDA/SCL bus, acting as the responder to the primary master's initiator. It oversamples SCL/SDA on the system clock and detects START/Sr/STOP. It matches the address header against its dynamic address or the 7'h7E broadcast, ACKs or NACKs, and then moves data bytes with T-bits: it receives write bytes into the local logic and serves read bytes from it. It sits between the device's open-drain pad and the target's register/CCC logic.

---
 rtl/i3c_target_sdr_responder_if.sv | 28 ++
 rtl/i3c_target_sdr_responder.sv | 207 ++++++++++++++++++++
 tb/tb_i3c_target_sdr_responder.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i3c_target_sdr_responder_if.sv
// Bus pins and local byte handshake of the I3C SDR target responder.
interface i3c_target_sdr_responder_if;
    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic [6:0] dyn_addr;
    logic       dyn_addr_valid;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ccc;
    logic       rx_parity_err;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underrun;
    logic       busy;

    modport slave (
        input  scl, sda_in, dyn_addr, dyn_addr_valid, tx_data, tx_last, tx_valid,
        output sda_oe, rx_data, rx_valid, rx_ccc, rx_parity_err, tx_ready, tx_underrun, busy
    );

    modport master (
        output scl, sda_in, dyn_addr, dyn_addr_valid, tx_data, tx_last, tx_valid,
        input  sda_oe, rx_data, rx_valid, rx_ccc, rx_parity_err, tx_ready, tx_underrun, busy
    );
endinterface

// File: rtl/i3c_target_sdr_responder.sv
// I3C target SDR private-transfer responder: header match, ACK/NACK, write and read bytes with T-bits.
// Optional macro I3C_TGT_PARITY_CHECK_EN rejects write frames whose T-bit fails odd parity.
module i3c_target_sdr_responder #(
    parameter int SYNC_STAGES = 2
) (
    input logic                       clk,
    input logic                       reset,
    i3c_target_sdr_responder_if.slave bus
);

    // The top state bit is set exactly in the states where a transfer is in progress.
    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        WAIT_STOP = 3'b001,
        ADDR      = 3'b100,
        ACK       = 3'b101,
        WR_DATA   = 3'b110,
        RD_DATA   = 3'b111
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclPrev_q;
    logic                   sdaPrev_q;
    logic [3:0]             bitCnt_q;
    logic [7:0]             shift_q;
    logic [7:0]             shift_d;
    logic [7:0]             txShift_q;
    logic                   txLast_q;
    logic                   rnw_q;
    logic                   isCcc_q;
    logic                   ackDriven_q;
    logic                   sdaOe_q;
    logic [7:0]             rxData_q;
    logic                   rxValid_q;
    logic                   rxCcc_q;
    logic                   txReady_q;
    logic                   txUnderrun_q;

    logic       sclS;
    logic       sdaS;
    logic       sclRise;
    logic       sclFall;
    logic       startDet;
    logic       stopDet;
    logic       bcast;
    logic       dynMatch;
    logic       hdrAck;
    logic       loadDue;
    logic [7:0] loadByte_d;
    logic       loadLast_d;

    assign sclS     = sclSync_q[SYNC_STAGES-1];
    assign sdaS     = sdaSync_q[SYNC_STAGES-1];
    assign sclRise  = sclS & ~sclPrev_q;
    assign sclFall  = ~sclS & sclPrev_q;
    assign startDet = sclS & sclPrev_q & sdaPrev_q & ~sdaS;
    assign stopDet  = sclS & sclPrev_q & ~sdaPrev_q & sdaS;
    assign shift_d  = {shift_q[6:0], sdaS};

    // A read header is only acknowledged when a byte is already waiting.
    assign bcast    = (shift_q[6:0] == 7'h7E);
    assign dynMatch = bus.dyn_addr_valid && (shift_q[6:0] == bus.dyn_addr);
    assign hdrAck   = bcast ? ~sdaS : (dynMatch & (~sdaS | bus.tx_valid));

    assign loadDue    = sclFall &&
                        (((state_q == ACK) && ackDriven_q && rnw_q) ||
                         ((state_q == RD_DATA) && (bitCnt_q == 4'd8) && !txLast_q));
    assign loadByte_d = bus.tx_valid ? bus.tx_data : 8'hFF;
    assign loadLast_d = bus.tx_valid ? bus.tx_last : 1'b1;

`ifdef I3C_TGT_PARITY_CHECK_EN
    logic rxParityErr_q;
    logic parityOk;
    assign parityOk          = (sdaS == ~^shift_q);
    assign bus.rx_parity_err = rxParityErr_q;
`else
    assign bus.rx_parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sclSync_q    <= '1;
            sdaSync_q    <= '1;
            sclPrev_q    <= 1'b1;
            sdaPrev_q    <= 1'b1;
            bitCnt_q     <= '0;
            shift_q      <= '0;
            txShift_q    <= '0;
            txLast_q     <= 1'b0;
            rnw_q        <= 1'b0;
            isCcc_q      <= 1'b0;
            ackDriven_q  <= 1'b0;
            sdaOe_q      <= 1'b0;
            rxData_q     <= '0;
            rxValid_q    <= 1'b0;
            rxCcc_q      <= 1'b0;
            txReady_q    <= 1'b0;
            txUnderrun_q <= 1'b0;
`ifdef I3C_TGT_PARITY_CHECK_EN
            rxParityErr_q <= 1'b0;
`endif
        end else begin
            sclSync_q    <= {sclSync_q[SYNC_STAGES-2:0], bus.scl};
            sdaSync_q    <= {sdaSync_q[SYNC_STAGES-2:0], bus.sda_in};
            sclPrev_q    <= sclS;
            sdaPrev_q    <= sdaS;
            rxValid_q    <= 1'b0;
            txReady_q    <= 1'b0;
            txUnderrun_q <= 1'b0;
`ifdef I3C_TGT_PARITY_CHECK_EN
            rxParityErr_q <= 1'b0;
`endif
            if (startDet) begin
                state_q  <= ADDR;
                bitCnt_q <= '0;
                sdaOe_q  <= 1'b0;
            end else if (stopDet) begin
                state_q <= IDLE;
                sdaOe_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ADDR: if (sclRise) begin
                        shift_q  <= shift_d;
                        bitCnt_q <= bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd7) begin
                            rnw_q       <= sdaS;
                            isCcc_q     <= bcast;
                            ackDriven_q <= 1'b0;
                            state_q     <= hdrAck ? ACK : WAIT_STOP;
                        end
                    end
                    ACK: if (sclFall) begin
                        if (!ackDriven_q) begin
                            sdaOe_q     <= 1'b1;
                            ackDriven_q <= 1'b1;
                        end else if (!rnw_q) begin
                            sdaOe_q  <= 1'b0;
                            bitCnt_q <= '0;
                            state_q  <= WR_DATA;
                        end
                    end
                    WR_DATA: if (sclRise) begin
                        if (bitCnt_q == 4'd8) begin
                            bitCnt_q <= '0;
`ifdef I3C_TGT_PARITY_CHECK_EN
                            if (!parityOk) begin
                                rxParityErr_q <= 1'b1;
                                state_q       <= WAIT_STOP;
                            end else begin
                                rxValid_q <= 1'b1;
                                rxData_q  <= shift_q;
                                rxCcc_q   <= isCcc_q;
                            end
`else
                            rxValid_q <= 1'b1;
                            rxData_q  <= shift_q;
                            rxCcc_q   <= isCcc_q;
`endif
                        end else begin
                            shift_q  <= shift_d;
                            bitCnt_q <= bitCnt_q + 4'd1;
                        end
                    end
                    // T-bit is !last, so pulling SDA low for T means the final byte.
                    RD_DATA: if (sclFall) begin
                        if (bitCnt_q == 4'd8) begin
                            if (txLast_q) begin
                                sdaOe_q <= 1'b0;
                                state_q <= WAIT_STOP;
                            end
                        end else if (bitCnt_q == 4'd7) begin
                            sdaOe_q  <= txLast_q;
                            bitCnt_q <= 4'd8;
                        end else begin
                            sdaOe_q   <= ~txShift_q[7];
                            txShift_q <= {txShift_q[6:0], 1'b0};
                            bitCnt_q  <= bitCnt_q + 4'd1;
                        end
                    end
                    default: ;
                endcase

                if (loadDue) begin
                    state_q      <= RD_DATA;
                    bitCnt_q     <= '0;
                    sdaOe_q      <= ~loadByte_d[7];
                    txShift_q    <= {loadByte_d[6:0], 1'b0};
                    txLast_q     <= loadLast_d;
                    txReady_q    <= bus.tx_valid;
                    txUnderrun_q <= ~bus.tx_valid;
                end
            end
        end
    end

    assign bus.sda_oe      = sdaOe_q;
    assign bus.rx_data     = rxData_q;
    assign bus.rx_valid    = rxValid_q;
    assign bus.rx_ccc      = rxCcc_q;
    assign bus.tx_ready    = txReady_q;
    assign bus.tx_underrun = txUnderrun_q;
    assign bus.busy        = state_q[2];

endmodule

// File: tb/tb_i3c_target_sdr_responder.sv
// Self-checking bench for the I3C SDR target responder: a bench-side master drives SCL/SDA,
// expected bytes go into scoreboard queues and are compared against what the target produced.
module tb_i3c_target_sdr_responder;
    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic reset;
    logic masterSda;

    i3c_target_sdr_responder_if bus();
    assign bus.sda_in = masterSda & ~bus.sda_oe;

    i3c_target_sdr_responder #(.SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] expRx[$];
    logic [8:0] obsRx[$];
    logic [8:0] expTx[$];
    int         expPerr;
    int         obsPerr;
    int         obsReady;
    int         obsUnder;
    logic       sawOe;
    logic       discard;

    // Collects every target output event away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_valid)      obsRx.push_back({bus.rx_ccc, bus.rx_data});
            if (bus.rx_parity_err) obsPerr++;
            if (bus.tx_ready)      obsReady++;
            if (bus.tx_underrun)   obsUnder++;
            if (bus.sda_oe)        sawOe = 1'b1;
        end
    end

    function automatic logic oddT(input logic [7:0] d);
        return ~^d;
    endfunction

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic beginTransfer();
        expRx.delete();
        obsRx.delete();
        expTx.delete();
        expPerr  = 0;
        obsPerr  = 0;
        obsReady = 0;
        obsUnder = 0;
        sawOe    = 1'b0;
        discard  = 1'b0;
    endtask

    task automatic busStart();
        masterSda = 1'b1;
        waitClocks(HALF);
        bus.scl = 1'b1;
        waitClocks(HALF);
        masterSda = 1'b0;
        waitClocks(HALF);
        bus.scl = 1'b0;
        discard = 1'b0;
    endtask

    task automatic busStop();
        waitClocks(HALF);
        masterSda = 1'b0;
        waitClocks(HALF);
        bus.scl = 1'b1;
        waitClocks(HALF);
        masterSda = 1'b1;
        waitClocks(HALF);
    endtask

    task automatic busBit(input logic b, output logic s);
        waitClocks(HALF);
        masterSda = b;
        waitClocks(HALF);
        bus.scl = 1'b1;
        waitClocks(HALF);
        s = bus.sda_in;
        waitClocks(HALF);
        bus.scl = 1'b0;
    endtask

    task automatic sendHeader(input logic [7:0] h, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) busBit(h[i], s);
        busBit(1'b1, ack);
    endtask

    // Pushes the model's expectation for one write frame, then clocks it out.
    task automatic writeFrame(input logic [7:0] d, input logic t, input logic ccc);
        logic s;
        if (!discard) begin
`ifdef I3C_TGT_PARITY_CHECK_EN
            if (t !== oddT(d)) begin
                expPerr++;
                discard = 1'b1;
            end else begin
                expRx.push_back({ccc, d});
            end
`else
            expRx.push_back({ccc, d});
`endif
        end
        for (int i = 7; i >= 0; i--) busBit(d[i], s);
        busBit(t, s);
    endtask

    task automatic readFrame(output logic [8:0] got);
        logic s;
        for (int i = 8; i >= 0; i--) begin
            busBit(1'b1, s);
            got[i] = s;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        waitClocks(3);
        checks++;
        if ({bus.sda_oe, bus.busy, bus.rx_valid, bus.rx_ccc, bus.rx_parity_err, bus.tx_ready, bus.tx_underrun} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b",
                     {bus.sda_oe, bus.busy, bus.rx_valid, bus.rx_ccc, bus.rx_parity_err, bus.tx_ready, bus.tx_underrun}, 7'b0);
        end
        checks++;
        if (bus.rx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_rx_data: got %h expected %h", bus.rx_data, 8'h00);
        end
        reset = 1'b0;
        waitClocks(4);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_busy: got %b expected %b", bus.busy, 1'b0);
        end
    endtask

    task automatic test_write();
        logic ack;
        logic [8:0] e, o;
        beginTransfer();
        busStart();
        sendHeader(8'h6A, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL write_ack: got %b expected %b", ack, 1'b0); end
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL write_busy: got %b expected %b", bus.busy, 1'b1); end
        writeFrame(8'hA5, 1'b1, 1'b0);
        busStop();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL write_busy_stop: got %b expected %b", bus.busy, 1'b0); end
        checks++;
        if (obsRx.size() !== expRx.size()) begin errors++; $display("[TB] FAIL write_count: got %0d expected %0d", obsRx.size(), expRx.size()); end
        while (expRx.size() > 0 && obsRx.size() > 0) begin
            e = expRx.pop_front();
            o = obsRx.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL write_byte: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_ccc();
        logic ack;
        logic [8:0] e, o;
        beginTransfer();
        busStart();
        sendHeader(8'hFC, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL ccc_ack: got %b expected %b", ack, 1'b0); end
        writeFrame(8'h06, 1'b0, 1'b1);
        busStop();
        checks++;
        if (obsPerr !== expPerr) begin errors++; $display("[TB] FAIL ccc_perr: got %0d expected %0d", obsPerr, expPerr); end
        checks++;
        if (obsRx.size() !== expRx.size()) begin errors++; $display("[TB] FAIL ccc_count: got %0d expected %0d", obsRx.size(), expRx.size()); end
        while (expRx.size() > 0 && obsRx.size() > 0) begin
            e = expRx.pop_front();
            o = obsRx.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL ccc_byte: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic ack;
        logic [8:0] e, o;
        beginTransfer();
        busStart();
        sendHeader(8'h6A, ack);
        writeFrame(8'h12, oddT(8'h12), 1'b0);
        writeFrame(8'h34, oddT(8'h34), 1'b0);
        busStart();
        sendHeader(8'hFC, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL b2b_sr_ack: got %b expected %b", ack, 1'b0); end
        writeFrame(8'h07, oddT(8'h07), 1'b1);
        busStop();
        checks++;
        if (obsRx.size() !== expRx.size()) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", obsRx.size(), expRx.size()); end
        while (expRx.size() > 0 && obsRx.size() > 0) begin
            e = expRx.pop_front();
            o = obsRx.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL b2b_byte: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_parity();
        logic ack;
        logic [8:0] e, o;
        beginTransfer();
        busStart();
        sendHeader(8'h6A, ack);
        writeFrame(8'h0F, ~oddT(8'h0F), 1'b0);
        writeFrame(8'h55, oddT(8'h55), 1'b0);
        busStop();
        checks++;
        if (obsPerr !== expPerr) begin errors++; $display("[TB] FAIL parity_err: got %0d expected %0d", obsPerr, expPerr); end
        checks++;
        if (obsRx.size() !== expRx.size()) begin errors++; $display("[TB] FAIL parity_count: got %0d expected %0d", obsRx.size(), expRx.size()); end
        while (expRx.size() > 0 && obsRx.size() > 0) begin
            e = expRx.pop_front();
            o = obsRx.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL parity_byte: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_read();
        logic ack;
        logic [8:0] got, e;
        beginTransfer();
        bus.tx_data  = 8'h3C;
        bus.tx_last  = 1'b0;
        bus.tx_valid = 1'b1;
        expTx.push_back({8'h3C, 1'b1});
        busStart();
        sendHeader(8'h6B, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL read_ack: got %b expected %b", ack, 1'b0); end
        waitClocks(HALF);
        bus.tx_data = 8'hC3;
        bus.tx_last = 1'b1;
        expTx.push_back({8'hC3, 1'b0});
        for (int f = 0; f < 2; f++) begin
            readFrame(got);
            e = expTx.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("[TB] FAIL read_frame%0d: got %h expected %h", f, got, e); end
        end
        bus.tx_valid = 1'b0;
        waitClocks(HALF);
        checks++;
        if ({bus.busy, bus.sda_oe} !== 2'b00) begin errors++; $display("[TB] FAIL read_wait_stop: got %b expected %b", {bus.busy, bus.sda_oe}, 2'b00); end
        checks++;
        if (obsReady !== 2) begin errors++; $display("[TB] FAIL read_ready: got %0d expected %0d", obsReady, 2); end
        checks++;
        if (obsUnder !== 0) begin errors++; $display("[TB] FAIL read_underrun: got %0d expected %0d", obsUnder, 0); end
        busStop();
    endtask

    task automatic test_underrun();
        logic ack;
        logic [8:0] got, e;
        beginTransfer();
        bus.tx_data  = 8'h81;
        bus.tx_last  = 1'b0;
        bus.tx_valid = 1'b1;
        expTx.push_back({8'h81, 1'b1});
        busStart();
        sendHeader(8'h6B, ack);
        waitClocks(HALF);
        bus.tx_valid = 1'b0;
        expTx.push_back({8'hFF, 1'b0});
        for (int f = 0; f < 2; f++) begin
            readFrame(got);
            e = expTx.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("[TB] FAIL underrun_frame%0d: got %h expected %h", f, got, e); end
        end
        waitClocks(HALF);
        checks++;
        if (obsUnder !== 1) begin errors++; $display("[TB] FAIL underrun_pulse: got %0d expected %0d", obsUnder, 1); end
        checks++;
        if (obsReady !== 1) begin errors++; $display("[TB] FAIL underrun_ready: got %0d expected %0d", obsReady, 1); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL underrun_busy: got %b expected %b", bus.busy, 1'b0); end
        busStop();
    endtask

    task automatic test_nomatch();
        logic ack;
        logic [8:0] got;
        beginTransfer();
        busStart();
        sendHeader(8'h22, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("[TB] FAIL nomatch_nack: got %b expected %b", ack, 1'b1); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL nomatch_busy: got %b expected %b", bus.busy, 1'b0); end
        writeFrame(8'hA5, 1'b1, 1'b0);
        expRx.delete();
        busStop();
        bus.tx_valid = 1'b0;
        busStart();
        sendHeader(8'h6B, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("[TB] FAIL nodata_nack: got %b expected %b", ack, 1'b1); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL nodata_busy: got %b expected %b", bus.busy, 1'b0); end
        readFrame(got);
        busStop();
        checks++;
        if (sawOe !== 1'b0) begin errors++; $display("[TB] FAIL nomatch_sda_oe: got %b expected %b", sawOe, 1'b0); end
        checks++;
        if (obsRx.size() !== 0) begin errors++; $display("[TB] FAIL nomatch_rx: got %0d expected %0d", obsRx.size(), 0); end
        checks++;
        if (obsReady + obsUnder !== 0) begin errors++; $display("[TB] FAIL nomatch_tx: got %0d expected %0d", obsReady + obsUnder, 0); end
    endtask

    task automatic test_reset_midread();
        logic ack;
        beginTransfer();
        bus.tx_data  = 8'h00;
        bus.tx_last  = 1'b1;
        bus.tx_valid = 1'b1;
        busStart();
        sendHeader(8'h6B, ack);
        waitClocks(HALF);
        checks++;
        if (bus.sda_oe !== 1'b1) begin errors++; $display("[TB] FAIL midread_drive: got %b expected %b", bus.sda_oe, 1'b1); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL midread_release: got %b expected %b", bus.sda_oe, 1'b0); end
        checks++;
        if ({bus.busy, bus.rx_valid, bus.rx_ccc, bus.rx_parity_err, bus.tx_ready, bus.tx_underrun, bus.rx_data} !== 14'b0) begin
            errors++;
            $display("[TB] FAIL midread_outputs: got %h expected %h",
                     {bus.busy, bus.rx_valid, bus.rx_ccc, bus.rx_parity_err, bus.tx_ready, bus.tx_underrun, bus.rx_data}, 14'b0);
        end
        waitClocks(2);
        reset = 1'b0;
        bus.tx_valid = 1'b0;
        masterSda = 1'b1;
        waitClocks(4);
        busStart();
        sendHeader(8'h6A, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_ack: got %b expected %b", ack, 1'b0); end
        busStop();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected %b", bus.busy, 1'b0); end
    endtask

    initial begin
        reset              = 1'b1;
        bus.scl            = 1'b1;
        masterSda          = 1'b1;
        bus.dyn_addr       = 7'h35;
        bus.dyn_addr_valid = 1'b1;
        bus.tx_data        = 8'h00;
        bus.tx_last        = 1'b0;
        bus.tx_valid       = 1'b0;
        beginTransfer();
        $display("[TB] starting i3c_target_sdr_responder bench");
        test_reset();
        test_write();
        test_ccc();
        test_back_to_back();
        test_parity();
        test_read();
        test_underrun();
        test_nomatch();
        test_reset_midread();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
